bin_to_bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It performs one shift per clock, with the add-3 correction applied combinationally in the same cycle. Conversions are started by a valid/ready handshake, and each result is reported with a one-cycle valid strobe. The output is range-checked, saturating to all nines on overflow. It is the general-purpose front end for the decimal display and readout paths.

---
 rtl/bin_to_bcd_seq.sv | 108 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter with valid/ready handshake.
// Define BIN_TO_BCD_SIGNED_EN for a two's-complement operand and a sign_op output.
module bin_to_bcd_seq #(
  parameter int BIN_W      = 13,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk_1mhz,
  input  logic                    reset_n_ip,
  input  logic                    start_ip,
  input  logic [BIN_W-1:0]        bin_data_ip,
  output logic                    ready_op,
  output logic [4*BCD_DIGITS-1:0] bcd_data_op,
  output logic                    bcd_valid_op,
  output logic                    ovf_op
`ifdef BIN_TO_BCD_SIGNED_EN
  ,
  output logic                    sign_op
`endif
);
  localparam int CW = $clog2(BIN_W) + 1;
  localparam int AW = 4 * BCD_DIGITS;

  generate
    if (BIN_W < 4 || BIN_W > 32 || BCD_DIGITS < 1 || BCD_DIGITS > 10) begin : g_bad_params
      $error("bin_to_bcd_seq: BIN_W must be 4..32 and BCD_DIGITS 1..10");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [BIN_W-1:0] sr, load_val;
  logic [AW-1:0]    acc, corr, shifted;
  logic [CW-1:0]    cnt;
  logic             sticky, sticky_n, last, sign_load;

`ifdef BIN_TO_BCD_SIGNED_EN
  logic sign_r;
  // Negation in BIN_W unsigned bits makes the most negative operand exact.
  assign load_val  = bin_data_ip[BIN_W-1] ? -bin_data_ip : bin_data_ip;
  assign sign_load = bin_data_ip[BIN_W-1] & (|load_val);
`else
  assign load_val  = bin_data_ip;
  assign sign_load = 1'b0;
`endif

  always_comb begin
    corr = acc;
    for (int i = 0; i < BCD_DIGITS; i++)
      corr[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end

  assign shifted  = {corr[AW-2:0], sr[BIN_W-1]};
  // A one leaving the top digit means the value no longer fits in BCD_DIGITS.
  assign sticky_n = sticky | corr[AW-1];
  assign last     = (cnt == CW'(BIN_W - 1));

  always_ff @(posedge clk_1mhz or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      state        <= IDLE;
      ready_op     <= 1'b1;
      bcd_valid_op <= 1'b0;
      ovf_op       <= 1'b0;
      bcd_data_op  <= '0;
      sr           <= '0;
      acc          <= '0;
      cnt          <= '0;
      sticky       <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
      sign_r       <= 1'b0;
      sign_op      <= 1'b0;
`endif
    end else begin
      bcd_valid_op <= 1'b0;
      if (state == IDLE) begin
        if (start_ip) begin
          sr       <= load_val;
          acc      <= '0;
          cnt      <= '0;
          sticky   <= 1'b0;
          state    <= SHIFT;
          ready_op <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
          sign_r   <= sign_load;
`endif
        end
      end else begin
        acc    <= shifted;
        sr     <= {sr[BIN_W-2:0], 1'b0};
        cnt    <= cnt + CW'(1);
        sticky <= sticky_n;
        if (last) begin
          bcd_data_op  <= sticky_n ? {BCD_DIGITS{4'h9}} : shifted;
          ovf_op       <= sticky_n;
          bcd_valid_op <= 1'b1;
          ready_op     <= 1'b1;
          state        <= IDLE;
`ifdef BIN_TO_BCD_SIGNED_EN
          sign_op      <= sign_r;
`endif
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = sign_load;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench for bin_to_bcd_seq (4-digit and 3-digit instances).
module tb_bin_to_bcd_seq;
  logic        clk_1mhz = 1'b0;
  logic        reset_n_ip;
  logic        start_ip, start3;
  logic [12:0] bin_data_ip, bin3;
  logic        ready_op, ready3, bcd_valid_op, valid3, ovf_op, ovf3;
  logic [15:0] bcd_data_op;
  logic [11:0] data3;
  logic        sign_op, sign3;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk_1mhz = ~clk_1mhz;

  bin_to_bcd_seq #(.BIN_W(13), .BCD_DIGITS(4)) dut (
    .clk_1mhz(clk_1mhz), .reset_n_ip(reset_n_ip), .start_ip(start_ip), .bin_data_ip(bin_data_ip),
    .ready_op(ready_op), .bcd_data_op(bcd_data_op), .bcd_valid_op(bcd_valid_op), .ovf_op(ovf_op)
`ifdef BIN_TO_BCD_SIGNED_EN
    , .sign_op(sign_op)
`endif
  );

  bin_to_bcd_seq #(.BIN_W(13), .BCD_DIGITS(3)) dut3 (
    .clk_1mhz(clk_1mhz), .reset_n_ip(reset_n_ip), .start_ip(start3), .bin_data_ip(bin3),
    .ready_op(ready3), .bcd_data_op(data3), .bcd_valid_op(valid3), .ovf_op(ovf3)
`ifdef BIN_TO_BCD_SIGNED_EN
    , .sign_op(sign3)
`endif
  );

`ifndef BIN_TO_BCD_SIGNED_EN
  assign sign_op = 1'b0;
  assign sign3   = 1'b0;
`endif

  function automatic longint mag_of(input logic [12:0] b);
`ifdef BIN_TO_BCD_SIGNED_EN
    return b[12] ? 64'd8192 - longint'(b) : longint'(b);
`else
    return longint'(b);
`endif
  endfunction

  function automatic logic sign_of(input logic [12:0] b);
`ifdef BIN_TO_BCD_SIGNED_EN
    return b[12];
`else
    return 1'b0;
`endif
  endfunction

  // Decimal digits by division; saturates to all nines above 10^d-1.
  function automatic logic [39:0] model_bcd(input longint v, input int d, output logic ovf);
    logic [39:0] r = '0;
    longint lim = 1;
    longint x = v;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ovf = (v > lim - 1);
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = ovf ? 4'h9 : 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic run_conv(input bit sel, input logic [12:0] v, output int lat, output int rlow,
                          output logic [15:0] d, output logic o, output logic s);
    if (sel) begin start3 = 1'b1; bin3 = v; end
    else begin start_ip = 1'b1; bin_data_ip = v; end
    step();
    start3 = 1'b0;
    start_ip = 1'b0;
    lat = 0;
    rlow = 0;
    while (1) begin
      if (!(sel ? ready3 : ready_op)) rlow++;
      if ((sel ? valid3 : bcd_valid_op) || lat >= 40) break;
      bin_data_ip = 13'($urandom);
      bin3 = 13'($urandom);
      step();
      lat++;
    end
    d = sel ? {4'h0, data3} : bcd_data_op;
    o = sel ? ovf3 : ovf_op;
    s = sel ? sign3 : sign_op;
  endtask

  task automatic test_reset();
    reset_n_ip = 1'b0;
    start_ip = 1'b0; start3 = 1'b0; bin_data_ip = '0; bin3 = '0;
    step();
    step();
    checks++; if (ready_op !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready_op); end
    checks++; if (bcd_valid_op !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bcd_valid_op); end
    checks++; if (bcd_data_op !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", bcd_data_op); end
    checks++; if (ovf_op !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf_op); end
    checks++; if (sign_op !== 1'b0) begin fails++; $display("FAIL reset_sign got %b want 0", sign_op); end
    reset_n_ip = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat, rlow;
    logic [15:0] d;
    logic o, s, eo;
    logic [39:0] e;
    e = model_bcd(mag_of(13'd8000), 4, eo);
    run_conv(1'b0, 13'd8000, lat, rlow, d, o, s);
    checks++; if (lat != 13) begin fails++; $display("FAIL basic_latency got %0d want 13", lat); end
    checks++; if (rlow != 13) begin fails++; $display("FAIL basic_ready_low got %0d want 13", rlow); end
    checks++; if (d !== e[15:0]) begin fails++; $display("FAIL basic_data got %h want %h", d, e[15:0]); end
    checks++; if (o !== eo) begin fails++; $display("FAIL basic_ovf got %b want %b", o, eo); end
    checks++; if (ready_op !== 1'b1) begin fails++; $display("FAIL basic_ready_with_valid got %b want 1", ready_op); end
    step();
    checks++; if (bcd_valid_op !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b want 0", bcd_valid_op); end
    checks++; if (bcd_data_op !== e[15:0]) begin fails++; $display("FAIL basic_data_hold got %h want %h", bcd_data_op, e[15:0]); end
  endtask

  task automatic test_corners();
    logic [12:0] vals [6] = '{13'd0, 13'd9, 13'd10, 13'd99, 13'd1234, 13'd8191};
    int lat, rlow;
    logic [15:0] d;
    logic o, s, eo;
    logic [39:0] e;
    foreach (vals[i]) begin
      e = model_bcd(mag_of(vals[i]), 4, eo);
      run_conv(1'b0, vals[i], lat, rlow, d, o, s);
      step();
      checks++; if (d !== e[15:0] || o !== eo || lat != 13)
        begin fails++; $display("FAIL corner_%0d got %h/%b/%0d want %h/%b/13", vals[i], d, o, lat, e[15:0], eo); end
    end
  endtask

  task automatic test_overflow3();
    logic [12:0] vals [3] = '{13'd999, 13'd1000, 13'd5};
    int lat, rlow;
    logic [15:0] d;
    logic o, s, eo;
    logic [39:0] e;
    foreach (vals[i]) begin
      e = model_bcd(mag_of(vals[i]), 3, eo);
      run_conv(1'b1, vals[i], lat, rlow, d, o, s);
      step();
      checks++; if (d[11:0] !== e[11:0] || o !== eo)
        begin fails++; $display("FAIL ovf3_%0d got %h/%b want %h/%b", vals[i], d[11:0], o, e[11:0], eo); end
    end
  endtask

  task automatic test_random();
    int lat, rlow;
    logic [15:0] d;
    logic o, s, eo;
    logic [39:0] e;
    logic [12:0] v;
    for (int i = 0; i < 30; i++) begin
      bit sel = (i % 2) == 1;
      v = 13'($urandom);
      e = model_bcd(mag_of(v), sel ? 3 : 4, eo);
      if (sel) e[15:12] = 4'h0;
      run_conv(sel, v, lat, rlow, d, o, s);
      step();
      checks++; if (d !== e[15:0] || o !== eo || s !== (sign_of(v) && mag_of(v) != 0) || lat != 13)
        begin fails++; $display("FAIL random_%0d_%h got %h/%b/%b/%0d want %h/%b/13", sel, v, d, o, s, lat, e[15:0], eo); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic eo;
    logic [39:0] e1, e2;
    e1 = model_bcd(mag_of(13'd1234), 4, eo);
    e2 = model_bcd(mag_of(13'd56), 4, eo);
    start_ip = 1'b1;
    bin_data_ip = 13'd1234;
    step();
    n = 0;
    while (!bcd_valid_op && n < 40) begin bin_data_ip = 13'($urandom); step(); n++; end
    checks++; if (n != 13 || bcd_data_op !== e1[15:0])
      begin fails++; $display("FAIL b2b_first got %h after %0d want %h after 13", bcd_data_op, n, e1[15:0]); end
    bin_data_ip = 13'd56;
    step();
    start_ip = 1'b0;
    checks++; if (bcd_valid_op !== 1'b0 || ready_op !== 1'b0)
      begin fails++; $display("FAIL b2b_accept got valid %b ready %b want 0 0", bcd_valid_op, ready_op); end
    n = 1;
    while (!bcd_valid_op && n < 40) begin bin_data_ip = 13'($urandom); step(); n++; end
    checks++; if (n != 14) begin fails++; $display("FAIL b2b_spacing got %0d want 14", n); end
    checks++; if (bcd_data_op !== e2[15:0]) begin fails++; $display("FAIL b2b_second got %h want %h", bcd_data_op, e2[15:0]); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, rlow, seen;
    logic [15:0] d;
    logic o, s, eo;
    logic [39:0] e;
    start_ip = 1'b1;
    bin_data_ip = 13'd4321;
    step();
    start_ip = 1'b0;
    repeat (5) step();
    reset_n_ip = 1'b0;
    #1;
    checks++; if (ready_op !== 1'b1 || bcd_valid_op !== 1'b0 || bcd_data_op !== 16'h0 || ovf_op !== 1'b0)
      begin fails++; $display("FAIL midreset_clear got %b/%b/%h/%b want 1/0/0000/0", ready_op, bcd_valid_op, bcd_data_op, ovf_op); end
    step();
    reset_n_ip = 1'b1;
    seen = 0;
    repeat (20) begin step(); if (bcd_valid_op !== 1'b0) seen++; end
    checks++; if (seen != 0) begin fails++; $display("FAIL midreset_no_valid got %0d pulses want 0", seen); end
    e = model_bcd(mag_of(13'd77), 4, eo);
    run_conv(1'b0, 13'd77, lat, rlow, d, o, s);
    step();
    checks++; if (d !== e[15:0] || o !== eo) begin fails++; $display("FAIL midreset_restart got %h/%b want %h/%b", d, o, e[15:0], eo); end
  endtask

`ifdef BIN_TO_BCD_SIGNED_EN
  task automatic test_signed();
    logic [12:0] vals [3] = '{13'h1000, 13'h1fff, 13'h0000};
    int lat, rlow;
    logic [15:0] d;
    logic o, s, eo;
    logic [39:0] e;
    foreach (vals[i]) begin
      e = model_bcd(mag_of(vals[i]), 4, eo);
      run_conv(1'b0, vals[i], lat, rlow, d, o, s);
      step();
      checks++; if (d !== e[15:0] || s !== (sign_of(vals[i]) && mag_of(vals[i]) != 0))
        begin fails++; $display("FAIL signed_%h got %h/%b want %h/%b", vals[i], d, s, e[15:0], sign_of(vals[i])); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_overflow3();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef BIN_TO_BCD_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
